// File: rtl/fetch_sequencer.sv
// fetch_sequencer -- fetch/execute sequencer with branch next-PC, fetch timeout and misalignment halt.
// Revision 1.0
`default_nettype none

module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruccion,
  output logic        instr_valid,
  input  logic        ex_done,
  input  logic        Cero,
  output logic [31:0] PC,
  output logic [31:0] retired,
  output logic        fault
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] cnt_inc;
  logic [31:0]   imm_b;
  logic [31:0]   next_pc;

  assign imem_addr = PC;
  assign cnt_inc   = wait_cnt + CW'(1);

  always_comb begin
    imm_b = {{19{Instruccion[31]}}, Instruccion[31], Instruccion[7],
             Instruccion[30:25], Instruccion[11:8], 1'b0};
    // Taken only when the ALU reports non-zero; wrap past 2^32 is intentional.
    if ((Instruccion[6:0] == OPC_BRANCH) && !Cero)
      next_pc = PC + imm_b;
    else
      next_pc = PC + 32'd4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      PC          <= RESET_PC;
      Instruccion <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
      retired     <= '0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
          wait_cnt <= '0;
        end
        FETCH: begin
          if (imem_ack) begin
            Instruccion <= imem_rdata;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= EXEC;
          end else if (cnt_inc == CW'(TIMEOUT)) begin
            wait_cnt <= cnt_inc;
            imem_req <= 1'b0;
            fault    <= 1'b1;
            state    <= HALT;
          end else begin
            wait_cnt <= cnt_inc;
          end
        end
        EXEC: begin
          if (ex_done) begin
            PC          <= next_pc;
            retired     <= retired + 32'd1;
            instr_valid <= 1'b0;
            wait_cnt    <= '0;
            // A misaligned target still commits PC and retired, then stops fetching.
            if (next_pc[1:0] != 2'b00) begin
              fault <= 1'b1;
              state <= HALT;
            end else begin
              imem_req <= 1'b1;
              state    <= FETCH;
            end
          end
        end
        HALT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          fault       <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer -- scoreboard-driven self-checking bench for fetch_sequencer.
// Revision 1.0
`default_nettype none

module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] Instruccion;
  logic        instr_valid;
  logic        ex_done = 1'b0;
  logic        Cero = 1'b0;
  logic [31:0] PC;
  logic [31:0] retired;
  logic        fault;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        cero;
    logic [31:0] npc;
    logic [31:0] ret;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_pc;
  logic [31:0] m_ret;

  fetch_sequencer #(.RESET_PC(32'h0), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .Instruccion(Instruccion), .instr_valid(instr_valid),
    .ex_done(ex_done), .Cero(Cero),
    .PC(PC), .retired(retired), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_npc(input logic [31:0] pc, input logic [31:0] ins,
                                            input logic cero);
    logic [12:0] imm13;
    imm13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    if (ins[6:0] == 7'h63 && cero == 1'b0)
      return pc + {{19{imm13[12]}}, imm13};
    return pc + 32'd4;
  endfunction

  task automatic plan(input logic [31:0] ins, input logic cero);
    exp_t e;
    e.addr  = m_pc;
    e.instr = ins;
    e.cero  = cero;
    e.npc   = model_npc(m_pc, ins, cero);
    e.ret   = m_ret + 32'd1;
    m_pc    = e.npc;
    m_ret   = e.ret;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    imem_ack = 1'b0;
    ex_done  = 1'b0;
    Cero     = 1'b0;
    m_pc     = 32'h0;
    m_ret    = 32'h0;
    sb.delete();
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  // Serves one fetch and one execute; junk acks are driven during EXEC to probe that they are ignored.
  task automatic run_instr(input logic [31:0] ins, input int stall, input int exlat, input logic cero,
                           output logic [31:0] addr, output logic stable,
                           output logic [31:0] ins_obs, output logic [31:0] ins_end,
                           output logic [31:0] pc_obs, output logic [31:0] ret_obs,
                           output logic fault_obs, output logic req_obs);
    addr = 'x; stable = 1'b0; ins_obs = 'x; ins_end = 'x;
    pc_obs = 'x; ret_obs = 'x; fault_obs = 1'bx; req_obs = 1'bx;
    for (int i = 0; i < 40 && !imem_req; i++) step();
    if (!imem_req) return;
    addr   = imem_addr;
    stable = 1'b1;
    for (int i = 0; i < stall; i++) begin
      step();
      if (!imem_req || imem_addr !== addr) stable = 1'b0;
    end
    imem_ack   = 1'b1;
    imem_rdata = ins;
    step();
    ins_obs = Instruccion;
    for (int i = 0; i < exlat; i++) begin
      imem_rdata = ~ins;
      step();
    end
    imem_ack = 1'b0;
    ins_end  = Instruccion;
    ex_done  = 1'b1;
    Cero     = cero;
    step();
    ex_done   = 1'b0;
    Cero      = 1'($urandom_range(0, 1));
    pc_obs    = PC;
    ret_obs   = retired;
    fault_obs = fault;
    req_obs   = imem_req;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    n_cmp += 6;
    if (PC !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", PC, 32'h0); end
    if (retired !== 32'h0) begin n_err++; $display("FAIL reset_retired: got %h want 0", retired); end
    if (Instruccion !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0", Instruccion); end
    if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", imem_req); end
    if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b want 0", fault); end
    rst_n = 1'b1;
    n_cmp++;
    if (imem_req !== 1'b0) begin n_err++; $display("FAIL idle_req: got %b want 0", imem_req); end
    step();
    n_cmp += 2;
    if (imem_req !== 1'b1) begin n_err++; $display("FAIL first_req: got %b want 1", imem_req); end
    if (imem_addr !== 32'h0) begin n_err++; $display("FAIL first_addr: got %h want 0", imem_addr); end
  endtask

  task automatic test_program(input string name, input logic [31:0] prog[], input logic ceros[]);
    logic [31:0] addr, ins_obs, ins_end, pc_obs, ret_obs;
    logic        stable, fault_obs, req_obs;
    exp_t        e;
    do_reset();
    foreach (prog[i]) plan(prog[i], ceros[i]);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front();
      run_instr(e.instr, i % 2, i % 3, e.cero, addr, stable, ins_obs, ins_end,
                pc_obs, ret_obs, fault_obs, req_obs);
      n_cmp += 6;
      if (addr !== e.addr) begin n_err++; $display("FAIL %s[%0d] addr: got %h want %h", name, i, addr, e.addr); end
      if (stable !== 1'b1) begin n_err++; $display("FAIL %s[%0d] req_stable: got %b want 1", name, i, stable); end
      if (ins_obs !== e.instr) begin n_err++; $display("FAIL %s[%0d] capture: got %h want %h", name, i, ins_obs, e.instr); end
      if (ins_end !== e.instr) begin n_err++; $display("FAIL %s[%0d] instr_hold: got %h want %h", name, i, ins_end, e.instr); end
      if (pc_obs !== e.npc) begin n_err++; $display("FAIL %s[%0d] next_pc: got %h want %h", name, i, pc_obs, e.npc); end
      if (ret_obs !== e.ret) begin n_err++; $display("FAIL %s[%0d] retired: got %h want %h", name, i, ret_obs, e.ret); end
    end
    n_cmp += 3;
    if (imem_req !== 1'b1) begin n_err++; $display("FAIL %s tail_req: got %b want 1", name, imem_req); end
    if (imem_addr !== m_pc) begin n_err++; $display("FAIL %s tail_addr: got %h want %h", name, imem_addr, m_pc); end
    if (fault !== 1'b0) begin n_err++; $display("FAIL %s tail_fault: got %b want 0", name, fault); end
  endtask

  task automatic test_stall();
    logic [31:0] addr, ins_obs, ins_end, pc_obs, ret_obs;
    logic        stable, fault_obs, req_obs;
    exp_t        e;
    do_reset();
    plan(32'h0050_0093, 1'b0);
    e = sb.pop_front();
    run_instr(e.instr, 5, 0, e.cero, addr, stable, ins_obs, ins_end, pc_obs, ret_obs, fault_obs, req_obs);
    n_cmp += 4;
    if (stable !== 1'b1) begin n_err++; $display("FAIL stall_stable: got %b want 1", stable); end
    if (addr !== e.addr) begin n_err++; $display("FAIL stall_addr: got %h want %h", addr, e.addr); end
    if (ins_obs !== e.instr) begin n_err++; $display("FAIL stall_capture: got %h want %h", ins_obs, e.instr); end
    if (pc_obs !== e.npc) begin n_err++; $display("FAIL stall_pc: got %h want %h", pc_obs, e.npc); end
  endtask

  task automatic test_timeout();
    int cnt;
    do_reset();
    for (int i = 0; i < 5 && !imem_req; i++) step();
    cnt = 0;
    while (imem_req && cnt < 40) begin
      cnt++;
      step();
    end
    n_cmp += 3;
    if (cnt !== 16) begin n_err++; $display("FAIL timeout_cycles: got %0d want 16", cnt); end
    if (fault !== 1'b1) begin n_err++; $display("FAIL timeout_fault: got %b want 1", fault); end
    if (imem_req !== 1'b0) begin n_err++; $display("FAIL timeout_req: got %b want 0", imem_req); end
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0013;
    repeat (8) step();
    imem_ack = 1'b0;
    n_cmp += 3;
    if (fault !== 1'b1) begin n_err++; $display("FAIL halt_sticky: got %b want 1", fault); end
    if (imem_req !== 1'b0) begin n_err++; $display("FAIL halt_req: got %b want 0", imem_req); end
    if (instr_valid !== 1'b0) begin n_err++; $display("FAIL halt_valid: got %b want 0", instr_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (fault !== 1'b0) begin n_err++; $display("FAIL halt_reset_fault: got %b want 0", fault); end
  endtask

  task automatic test_misaligned();
    logic [31:0] addr, ins_obs, ins_end, pc_obs, ret_obs;
    logic        stable, fault_obs, req_obs, any_req;
    exp_t        e;
    do_reset();
    plan(32'h0000_0363, 1'b0);
    e = sb.pop_front();
    run_instr(e.instr, 0, 0, e.cero, addr, stable, ins_obs, ins_end, pc_obs, ret_obs, fault_obs, req_obs);
    any_req = req_obs;
    repeat (6) begin
      step();
      any_req = any_req | imem_req;
    end
    n_cmp += 4;
    if (pc_obs !== 32'h6) begin n_err++; $display("FAIL misalign_pc: got %h want %h", pc_obs, 32'h6); end
    if (ret_obs !== 32'h1) begin n_err++; $display("FAIL misalign_retired: got %h want 1", ret_obs); end
    if (fault_obs !== 1'b1) begin n_err++; $display("FAIL misalign_fault: got %b want 1", fault_obs); end
    if (any_req !== 1'b0) begin n_err++; $display("FAIL misalign_req: got %b want 0", any_req); end
  endtask

  task automatic test_async_reset();
    logic [31:0] addr, ins_obs, ins_end, pc_obs, ret_obs;
    logic        stable, fault_obs, req_obs;
    do_reset();
    run_instr(32'h0400_0063, 0, 0, 1'b0, addr, stable, ins_obs, ins_end, pc_obs, ret_obs, fault_obs, req_obs);
    for (int i = 0; i < 5 && !imem_req; i++) step();
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0013;
    step();
    imem_ack = 1'b0;
    n_cmp += 2;
    if (PC !== 32'h40) begin n_err++; $display("FAIL arst_setup_pc: got %h want %h", PC, 32'h40); end
    if (instr_valid !== 1'b1) begin n_err++; $display("FAIL arst_setup_valid: got %b want 1", instr_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp += 3;
    if (PC !== 32'h0) begin n_err++; $display("FAIL arst_pc: got %h want 0", PC); end
    if (instr_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %b want 0", instr_valid); end
    if (retired !== 32'h0) begin n_err++; $display("FAIL arst_retired: got %h want 0", retired); end
    step();
    rst_n = 1'b1;
    run_instr(32'h0000_0013, 0, 0, 1'b0, addr, stable, ins_obs, ins_end, pc_obs, ret_obs, fault_obs, req_obs);
    n_cmp += 2;
    if (addr !== 32'h0) begin n_err++; $display("FAIL arst_restart_addr: got %h want 0", addr); end
    if (pc_obs !== 32'h4) begin n_err++; $display("FAIL arst_restart_pc: got %h want 4", pc_obs); end
  endtask

  initial begin
    logic [31:0] seq_prog[];
    logic        seq_cero[];
    logic [31:0] br_prog[];
    logic        br_cero[];
    seq_prog = '{32'h0000_0013, 32'h0000_0013, 32'h0000_0013};
    seq_cero = '{1'b0, 1'b1, 1'b0};
    br_prog  = '{32'hFE00_0EE3, 32'h0000_0013, 32'h1000_0063, 32'hFE00_0EE3,
                 32'h0000_0013, 32'hFE00_0EE3, 32'h0000_0363};
    br_cero  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    test_reset();
    test_program("sequential", seq_prog, seq_cero);
    test_program("branch", br_prog, br_cero);
    test_stall();
    test_timeout();
    test_misaligned();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL provide parameter TIMEOUT, default 16, maximum cycles to wait for imem_ack per fetch.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, in this port order:
  clk  input  1  single clock, rising edge
  rst_n  input  1  asynchronous active-low reset
  imem_req  output  1  fetch request to instruction memory
  imem_addr  output  32  fetch address, always equal to PC
  imem_ack  input  1  memory returns imem_rdata this cycle
  imem_rdata  input  32  fetched instruction word
  Instruccion  output  32  registered instruction under execution
  instr_valid  output  1  Instruccion valid for the datapath
  ex_done  input  1  datapath finished the current instruction; Cero valid
  Cero  input  1  ALU zero flag
  PC  output  32  current program counter
  retired  output  32  count of completed instructions
  fault  output  1  sticky error flag

Function
REQ-004 SHALL implement FSM states IDLE, FETCH, EXEC, HALT.
REQ-005 IDLE: all request/valid outputs low; SHALL move to FETCH on the first rising edge after reset release.
REQ-006 FETCH: imem_req=1 and imem_addr=PC, held stable until imem_ack.
REQ-007 FETCH with imem_ack=1: SHALL capture imem_rdata into Instruccion and enter EXEC next cycle; imem_req SHALL be low in EXEC.
REQ-008 FETCH timeout: wait counter SHALL reset on FETCH entry and increment each FETCH cycle without ack; when the counter reaches TIMEOUT with no ack, SHALL enter HALT.
REQ-009 imem_ack outside FETCH SHALL be ignored.
REQ-010 EXEC: instr_valid=1; Instruccion held constant; SHALL wait indefinitely for ex_done.
REQ-011 EXEC with ex_done=1: SHALL compute next PC from Instruccion and Cero sampled in that same cycle, register it into PC, increment retired, and return to FETCH; EXEC to FETCH SHALL take exactly one cycle.
REQ-012 Next-PC rule: if Instruccion[6:0]==7'b1100011 and Cero==0, next PC = PC + imm_b; otherwise, next PC = PC + 4.
REQ-013 imm_b SHALL equal {19{Instruccion[31]}}, Instruccion[31], Instruccion[7], Instruccion[30:25], Instruccion[11:8], 1'b0 (32 bits, sign-extended).
REQ-014 PC arithmetic SHALL be modulo 2^32; wrap past 32'hFFFF_FFFC is silent.
REQ-015 If the computed next PC has bits [1:0] != 0, SHALL enter HALT instead of FETCH.
  - On this path PC SHALL still take the faulting value.
  - retired SHALL still increment.
REQ-016 HALT: fault=1, imem_req=0, instr_valid=0; SHALL stay in HALT until reset.
REQ-017 retired SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-018 Fetch throughput: each instruction SHALL take at least 1 FETCH cycle plus 1 EXEC cycle, i.e. at least 2 cycles.

Reset
REQ-019 On rst_n=0, immediately and independent of clk, all of the following SHALL apply:
  - state=IDLE, PC=RESET_PC, Instruccion=0
  - imem_req=0, instr_valid=0, fault=0
  - retired=0, wait counter=0
REQ-020 Reset asserted mid-fetch or mid-exec SHALL abandon the operation; no partial PC or retired update.

Verification
REQ-021 Sequential fetch: RESET_PC=0; ack every fetch one cycle after the request; non-branch instructions; ex_done one cycle into EXEC -> imem_addr sequence 0,4,8,12; retired=3 after the third ex_done.
REQ-022 Branch taken: at PC=0x100, Instruccion=32'hFE000EE3 (imm_b=-4); Cero=0 at ex_done -> PC=0xFC.
  - Branch not taken: same instruction with Cero=1 -> PC=0x104.
REQ-023 Memory stall: hold imem_ack low for 5 cycles -> imem_req and imem_addr stable for all 6 FETCH cycles; instruction captured on the ack cycle.
REQ-024 Timeout: never ack, TIMEOUT=16 -> HALT entered, fault=1 and imem_req=0 after 16 request cycles; fault persists until rst_n=0.
REQ-025 Misaligned target: branch with imm_b=6 at PC=0 and Cero=0 -> PC=6, fault=1, no further imem_req.
REQ-026 Async reset during EXEC at PC=0x40 -> PC=RESET_PC and instr_valid=0 before the next clk edge; fetch restarts from RESET_PC.
